// File: rtl/mms_pkg.sv
// mms_pkg: shared TLB tag types, default widths and flush FSM state encoding
package mms_pkg;
    localparam int ASID_WD_DEF = 9;
    localparam int VPN_WD_DEF  = 20;
    typedef logic [VPN_WD_DEF-1:0] vpn_t;
    typedef struct packed {
        logic                   valid;
        vpn_t                   vpn;
        logic [ASID_WD_DEF-1:0] asid;
        logic                   g;
        logic                   superpage;
    } tlb_tag_entry_t;
    typedef enum logic {IDLE, FLUSH} flush_state_e;
endpackage

// File: rtl/tlb_tag_cam_entry.sv
// tlb_tag_cam_entry: one CAM tag with lookup/write/flush match; TLB_SUPERPAGE_EN adds the superpage bit
module tlb_tag_cam_entry
    import mms_pkg::*;
#(
    parameter int ASID_WD = ASID_WD_DEF,
    parameter int VPN_WD  = VPN_WD_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en,
    input  logic [VPN_WD-1:0]  wr_vpn,
    input  logic [ASID_WD-1:0] wr_asid,
    input  logic               wr_g,
    input  logic               wr_super,
    input  logic [VPN_WD-1:0]  lkp_vpn,
    input  logic [ASID_WD-1:0] lkp_asid,
    input  logic               flush_en,
    input  logic               flush_asid_en,
    input  logic [ASID_WD-1:0] flush_asid,
    input  logic               flush_vpn_en,
    input  logic [VPN_WD-1:0]  flush_vpn,
    output logic               valid,
    output logic               lkp_match,
    output logic               wr_match
);
    localparam int HI = VPN_WD / 2;
    logic               valid_q, g_q, superpage, flush_hit;
    logic [VPN_WD-1:0]  vpn_q;
    logic [ASID_WD-1:0] asid_q;
`ifdef TLB_SUPERPAGE_EN
    logic super_q;
    always_ff @(posedge clk_i)
        if (wr_en) super_q <= wr_super;
    assign superpage = super_q;
`else
    logic unused_super;
    assign unused_super = wr_super;
    assign superpage = 1'b0;
`endif
    function automatic logic vpn_hit(input logic [VPN_WD-1:0] a, input logic [VPN_WD-1:0] b, input logic s);
        return s ? a[VPN_WD-1:HI] == b[VPN_WD-1:HI] : a == b;
    endfunction
    assign valid     = valid_q;
    assign lkp_match = valid_q && vpn_hit(lkp_vpn, vpn_q, superpage) && (g_q || asid_q == lkp_asid);
    assign wr_match  = valid_q && vpn_hit(wr_vpn, vpn_q, superpage) && (g_q || asid_q == wr_asid);
    // ASID-selective flushes spare global entries; a flush with no qualifiers hits everything
    assign flush_hit = (!flush_asid_en || (asid_q == flush_asid && !g_q)) &&
                       (!flush_vpn_en || vpn_hit(flush_vpn, vpn_q, superpage));
    always_ff @(posedge clk_i) begin
        if (rst_i) valid_q <= 1'b0;
        else if (wr_en) valid_q <= 1'b1;
        else if (flush_en && flush_hit) valid_q <= 1'b0;
    end
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            vpn_q  <= wr_vpn;
            asid_q <= wr_asid;
            g_q    <= wr_g;
        end
    end
endmodule

// File: rtl/tlb_tag_cam.sv
// tlb_tag_cam: TLB tag CAM with 1-cycle lookup, victim-selecting write and selective flush; TLB_SUPERPAGE_EN enables superpages
module tlb_tag_cam
    import mms_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int ASID_WD = ASID_WD_DEF,
    parameter int VPN_WD  = VPN_WD_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       lkp_valid_i,
    input  logic [VPN_WD-1:0]          lkp_vpn_i,
    input  logic [ASID_WD-1:0]         lkp_asid_i,
    output logic                       lkp_valid_o,
    output logic                       lkp_hit_o,
    output logic [ENTRIES-1:0]         lkp_hit_vec_o,
    output logic [$clog2(ENTRIES)-1:0] lkp_idx_o,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [VPN_WD-1:0]          wr_vpn_i,
    input  logic [ASID_WD-1:0]         wr_asid_i,
    input  logic                       wr_g_i,
    input  logic                       wr_super_i,
    output logic [$clog2(ENTRIES)-1:0] wr_idx_o,
    input  logic                       flush_valid_i,
    output logic                       flush_ready_o,
    input  logic                       flush_asid_en_i,
    input  logic [ASID_WD-1:0]         flush_asid_i,
    input  logic                       flush_vpn_en_i,
    input  logic [VPN_WD-1:0]          flush_vpn_i,
    output logic                       flush_done_o
);
    localparam int IW = $clog2(ENTRIES);
    flush_state_e       state_q, state_d;
    logic [ENTRIES-1:0] lkp_match, wr_match, valid, hit_vec_q;
    logic               lkp_valid_q, flush_done_q, wr_fire, flush_fire, rr_used;
    logic               f_asid_en_q, f_vpn_en_q;
    logic [ASID_WD-1:0] f_asid_q;
    logic [VPN_WD-1:0]  f_vpn_q;
    logic [IW-1:0]      rr_q, victim;
    function automatic logic [IW-1:0] lowest(input logic [ENTRIES-1:0] v);
        lowest = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (v[i]) lowest = IW'(i);
    endfunction
    assign flush_ready_o = state_q == IDLE;
    assign wr_ready_o    = flush_ready_o && !flush_valid_i;
    assign wr_fire       = wr_valid_i && wr_ready_o;
    assign flush_fire    = flush_valid_i && flush_ready_o;
    // overwrite a matching tag first so the CAM never holds duplicates
    assign rr_used  = !(|wr_match) && &valid;
    assign victim   = |wr_match ? lowest(wr_match) : rr_used ? rr_q : lowest(~valid);
    assign wr_idx_o = victim;
    assign lkp_valid_o   = lkp_valid_q;
    assign lkp_hit_vec_o = hit_vec_q;
    assign lkp_hit_o     = |hit_vec_q;
    assign lkp_idx_o     = lowest(hit_vec_q);
    assign flush_done_o  = flush_done_q;
    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        tlb_tag_cam_entry #(.ASID_WD(ASID_WD), .VPN_WD(VPN_WD)) u_entry (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .wr_en         (wr_fire && victim == IW'(e)),
            .wr_vpn        (wr_vpn_i),
            .wr_asid       (wr_asid_i),
            .wr_g          (wr_g_i),
            .wr_super      (wr_super_i),
            .lkp_vpn       (lkp_vpn_i),
            .lkp_asid      (lkp_asid_i),
            .flush_en      (state_q == FLUSH),
            .flush_asid_en (f_asid_en_q),
            .flush_asid    (f_asid_q),
            .flush_vpn_en  (f_vpn_en_q),
            .flush_vpn     (f_vpn_q),
            .valid         (valid[e]),
            .lkp_match     (lkp_match[e]),
            .wr_match      (wr_match[e])
        );
    end
    always_comb state_d = flush_fire ? FLUSH : IDLE;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            lkp_valid_q  <= 1'b0;
            hit_vec_q    <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lkp_valid_q  <= lkp_valid_i;
            hit_vec_q    <= lkp_valid_i ? lkp_match : '0;
            flush_done_q <= state_q == FLUSH;
            if (wr_fire && rr_used) rr_q <= rr_q + 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (flush_fire) begin
            f_asid_en_q <= flush_asid_en_i;
            f_asid_q    <= flush_asid_i;
            f_vpn_en_q  <= flush_vpn_en_i;
            f_vpn_q     <= flush_vpn_i;
        end
    end
endmodule

// File: doc/tlb_tag_cam.md
TLB_TAG_CAM -- requirements
Module: tlb_tag_cam

Interface
REQ-001 Parameter ENTRIES, default 8, number of CAM entries (power of two, >=2).
REQ-002 Parameter ASID_WD, default 9, ASID width.
REQ-003 Parameter VPN_WD, default 20, VPN width (two equal levels, VPN[1] high half, VPN[0] low half).
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 lkp_valid_i  in  1; lkp_vpn_i  in  VPN_WD; lkp_asid_i  in  ASID_WD  lookup request.
REQ-007 lkp_valid_o  out  1; lkp_hit_o  out  1; lkp_hit_vec_o  out  ENTRIES; lkp_idx_o  out  $clog2(ENTRIES)  lookup result.
REQ-008 wr_valid_i  in  1; wr_ready_o  out  1; wr_vpn_i  in  VPN_WD; wr_asid_i  in  ASID_WD; wr_g_i  in  1 (global); wr_super_i  in  1 (superpage); wr_idx_o  out  $clog2(ENTRIES)  entry written.
REQ-009 flush_valid_i  in  1; flush_ready_o  out  1; flush_asid_en_i  in  1; flush_asid_i  in  ASID_WD; flush_vpn_en_i  in  1; flush_vpn_i  in  VPN_WD; flush_done_o  out  1  selective flush.

Function
REQ-010 Entry holds valid, vpn, asid, g, super; match = valid && vpn match && (g || asid equal).
REQ-011 VPN match: full VPN compare; if super set, VPN[1] only.
REQ-012 Lookup latency exactly 1 cycle: lkp_valid_o = registered lkp_valid_i; hit_vec/hit/idx registered from pre-edge contents.
REQ-013 lkp_idx_o = lowest set bit of lkp_hit_vec_o; 0 when no hit; hit_vec/hit zero when lkp_valid_o low.
REQ-014 Write handshake: accepted when wr_valid_i && wr_ready_o at edge; entry updated that edge; wr_idx_o combinational, valid while wr_valid_i.
REQ-015 Write victim priority: existing entry matching wr_vpn/wr_asid (overwrite, no duplicates) > lowest-index invalid entry > round-robin pointer.
REQ-016 Round-robin pointer advances (wraps ENTRIES-1 -> 0) only when it supplied the victim.
REQ-017 Same-cycle lookup and write: lookup returns pre-write contents.
REQ-018 Flush FSM states IDLE, FLUSH; IDLE -> FLUSH on flush_valid_i && flush_ready_o; FLUSH -> IDLE unconditionally next cycle.
REQ-019 flush_ready_o = (state==IDLE); wr_ready_o = (state==IDLE) && !flush_valid_i (flush wins over simultaneous write).
REQ-020 Flush operands latched at acceptance; in FLUSH every entry with (!asid_en || (asid equal && !g)) && (!vpn_en || VPN match per REQ-011) is invalidated at end of cycle.
REQ-021 asid_en=0, vpn_en=0 invalidates all entries, including global.
REQ-022 flush_done_o pulses 1 cycle, registered, the cycle after FLUSH.
REQ-023 Lookups issued in FLUSH cycle return pre-flush contents; lookups after it see flushed state.
REQ-024 Lookups never stall; no backpressure on lookup port.

Reset
REQ-025 rst_i high: all valid bits 0, pointer 0, state IDLE, lkp_valid_o/lkp_hit_o/flush_done_o 0, hit_vec 0, idx 0.
REQ-026 Reset during FLUSH aborts it; flush_done_o not asserted for aborted flush.
REQ-027 vpn/asid/g/super storage not reset.

Configuration
REQ-028 Macro TLB_SUPERPAGE_EN: defined -> wr_super_i stored, REQ-011 superpage match active.
REQ-029 Undefined -> wr_super_i ignored, super bit not implemented, all matches full-VPN.

Structure
REQ-030 mms_pkg holds vpn_t, tlb_tag_entry_t (valid, vpn, asid, g, super) and default ASID/VPN width constants.
REQ-031 One sub-module tlb_tag_cam_entry: single entry storage, lookup match, flush match.
REQ-032 Victim selection and flush FSM live in top level.

Verification (ENTRIES=8)
REQ-033 Write vpn=0x12345 asid=3 g=0, next cycle lookup same -> lkp_hit_o=1, idx=0, one cycle later; lookup asid=4 -> miss.
REQ-034 Fill 8 distinct entries, write 9th and 10th -> wr_idx_o=0 then 1; rewrite existing vpn -> its index, pointer unchanged.
REQ-035 Entries asid 1 and 2 plus global, flush asid_en=1 asid=1 -> only asid-1 non-global invalid; done pulse 2 cycles after acceptance.
REQ-036 flush_valid_i and wr_valid_i same cycle in IDLE -> wr_ready_o=0, flush accepted, write accepted after return to IDLE.
REQ-037 TLB_SUPERPAGE_EN: super entry vpn=0x40000, lookup 0x403FF -> hit; without macro -> miss.
REQ-038 rst_i asserted in FLUSH -> all invalid, state IDLE, no flush_done_o.
